// File: rtl/shift_add_mult.sv
// Sequential signed 32x32 multiplier: one multiplier bit per cycle, 32-cycle latency.
// Returns the low 32 product bits plus a signed-overflow flag and a one-cycle ready strobe.
module shift_add_mult (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [63:0] acc_q,    acc_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [31:0] result_q, result_d;
  logic        exc_q,    exc_d;
  logic        rdy_q,    rdy_d;
  logic        busy_q,   busy_d;

  logic [63:0] term_s;
  logic [63:0] acc_step_s;

  // Sign-extended multiplicand weighted by the current multiplier bit position.
  function automatic logic [63:0] partial_term(input logic [31:0] a, input logic [4:0] i);
    partial_term = {{32{a[31]}}, a} << i;
  endfunction

  // The product fits in 32 signed bits only when bits [63:31] are all copies of the sign.
  function automatic logic sign_overflow(input logic [63:0] acc);
    sign_overflow = !((&acc[63:31]) || (~|acc[63:31]));
  endfunction

  // Accumulator step for the bit under the counter; bit 31 carries negative weight.
  always_comb begin
    term_s = partial_term(a_q, cnt_q);
    if (b_q[cnt_q]) begin
      if (cnt_q == 5'd31) begin
        acc_step_s = acc_q - term_s;
      end else begin
        acc_step_s = acc_q + term_s;
      end
    end else begin
      acc_step_s = acc_q;
    end
  end

  // Next-state and datapath control; a start pulse wins in every state, aborting any run.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_MULT) begin
      a_d     = data_operandA;
      b_d     = data_operandB;
      acc_d   = 64'd0;
      cnt_d   = 5'd0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN: begin
          acc_d = acc_step_s;
          if (cnt_q == 5'd31) begin
            result_d = acc_step_s[31:0];
            exc_d    = sign_overflow(acc_step_s);
            rdy_d    = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 The port `clock` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port `reset` SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 The port `ctrl_MULT` SHALL be an input, 1 bit wide: start pulse, sampled on each rising edge.
REQ-005 The port `data_operandA` SHALL be an input, 32 bits wide: multiplicand, two's complement.
REQ-006 The port `data_operandB` SHALL be an input, 32 bits wide: multiplier, two's complement.
REQ-007 The port `data_result` SHALL be an output, 32 bits wide: low 32 bits of the product, registered.
REQ-008 The port `data_exception` SHALL be an output, 1 bit wide: signed overflow flag, registered.
REQ-009 The port `data_resultRDY` SHALL be an output, 1 bit wide: one-cycle completion strobe.
REQ-010 The port `busy` SHALL be an output, 1 bit wide: high while an operation is in progress.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE; the state after reset SHALL be IDLE.
REQ-012 In IDLE or DONE, when `ctrl_MULT` is sampled high at edge k, the block SHALL:
- capture `data_operandA` and `data_operandB` into internal registers;
- clear the 64-bit accumulator and the 5-bit iteration counter;
- enter RUN.
REQ-013 In RUN, each edge SHALL process one multiplier bit, i = counter value (0..31): if captured B[i]=1, add captured A, sign-extended to 64 bits and shifted left by i, to the accumulator.
REQ-014 B[31] SHALL carry negative weight: at i=31 the shifted term is subtracted rather than added, so that the product is exact in two's complement.
REQ-015 On the edge that processes i=31, the block SHALL:
- load `data_result` with accumulator bits [31:0];
- set `data_exception`=1 if accumulator bits [63:31] are not all equal;
- assert `data_resultRDY`;
- enter DONE.
REQ-016 Latency SHALL be exactly 32 cycles: a start sampled at edge k yields `data_resultRDY`=1 during the cycle following edge k+32.
REQ-017 `data_resultRDY` SHALL be high for exactly one cycle per completed operation.
REQ-018 DONE SHALL return to IDLE on the next edge unless `ctrl_MULT` is high, in which case it SHALL start a new operation per REQ-012.
REQ-019 `busy` SHALL be 1 exactly while the state is RUN, and 0 in IDLE and DONE.
REQ-020 `data_result` and `data_exception` SHALL hold their values until the next completion or reset; they SHALL not change during RUN.
REQ-021 A `ctrl_MULT` sampled high during RUN SHALL abort the current operation, with no `data_resultRDY` for it, and restart per REQ-012 with the new operands; the counter restarts at 0.
REQ-022 Changes on the operand inputs after capture SHALL have no effect on the operation in progress.
REQ-023 An operand of zero SHALL still take the full 32 cycles; there SHALL be no early termination.

Reset
REQ-024 When `reset` is high at a rising edge, the block SHALL:
- set the state to IDLE;
- clear the accumulator, counter and operand registers;
- set `data_result`=0, `data_exception`=0, `data_resultRDY`=0 and `busy`=0.
REQ-025 Reset SHALL take priority over `ctrl_MULT` on the same edge.
REQ-026 Reset asserted during RUN SHALL discard the operation; no `data_resultRDY` SHALL follow.
REQ-027 Outputs before the first reset edge SHALL be don't-care.

Verification
REQ-028 The bench SHALL drive A=3, B=4 with a single `ctrl_MULT` pulse and require:
- `busy`=1 for 32 cycles;
- then `data_resultRDY`=1 for 1 cycle with `data_result`=12 and `data_exception`=0.
REQ-029 The bench SHALL drive A=-7, B=6 and require `data_result`=0xFFFFFFD6 and `data_exception`=0.
REQ-030 The bench SHALL cover overflow and boundary cases:
- A=0x00010000, B=0x00010000 -> `data_result`=0x00000000, `data_exception`=1;
- A=0x80000000, B=0xFFFFFFFF -> `data_result`=0x80000000, `data_exception`=1;
- A=0x7FFFFFFF, B=1 -> `data_result`=0x7FFFFFFF, `data_exception`=0.
REQ-031 The bench SHALL start A=5, B=5, then pulse `ctrl_MULT` with A=2, B=9 at cycle 10 of RUN, and require:
- a single `data_resultRDY` 32 cycles after the second pulse;
- `data_result`=18.
REQ-032 The bench SHALL start A=100, B=100 and assert `reset` at cycle 15, and require:
- all outputs 0 on the next cycle;
- `data_resultRDY` never asserted;
- a subsequent A=-1, B=-1 operation yields `data_result`=1 and `data_exception`=0.
REQ-033 The bench SHALL hold `ctrl_MULT` high across DONE (back-to-back operations) and require:
- a new operation starts with no idle cycle between them;
- `data_resultRDY` pulses every 33 cycles.
